// File: rtl/la_wb_pkg.sv
// Shared types for the logic-analyser Wishbone initiator.
package la_wb_pkg;

    localparam int unsigned LA_WB_ADDR_W = 32;
    localparam int unsigned LA_WB_DATA_W = 32;
    localparam int unsigned LA_WB_SEL_W  = LA_WB_DATA_W / 8;
    // Width of the timeout counter; covers limits up to 65535.
    localparam int unsigned LA_WB_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } la_wb_state_e;

    // Command captured on acceptance and presented on the bus.
    typedef struct packed {
        logic                    we;
        logic [LA_WB_ADDR_W-1:0] adr;
        logic [LA_WB_DATA_W-1:0] dat;
        logic [LA_WB_SEL_W-1:0]  sel;
    } la_wb_cmd_t;

endpackage

// File: rtl/la_wb_timeout_ctr.sv
// Counts BUS cycles without acknowledge; o_expired is high in the cycle
// that is the i_limit-th one since the last clear.
module la_wb_timeout_ctr
    import la_wb_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clear,
    input  logic                   i_enable,
    input  logic [LA_WB_CNT_W-1:0] i_limit,
    output logic                   o_expired
);

    logic [LA_WB_CNT_W-1:0] r_count;

    // Current cycle is the (r_count+1)-th waiting cycle.
    assign o_expired = ({1'b0, r_count} + 17'd1) >= {1'b0, i_limit};

    // Cleared on bus entry, advances on each unacknowledged cycle; holds at the limit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/la_wb_initiator.sv
// Wishbone classic single-transfer initiator driven by valid/ready command
// beats; returns read data / timeout status on a response channel.
// Optional bus timeout is built in when LA_WB_TIMEOUT_EN is defined.
module la_wb_initiator
    import la_wb_pkg::*;
#(
    parameter int unsigned ADDR_W         = LA_WB_ADDR_W,
    parameter int unsigned DATA_W         = LA_WB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_adr,
    input  logic [DATA_W-1:0]   cmd_dat,
    input  logic [DATA_W/8-1:0] cmd_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_dat,
    output logic                rsp_err,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    input  logic [DATA_W-1:0]   wbm_dat_i,
    input  logic                wbm_ack_i
);

    localparam int unsigned SEL_W = DATA_W / 8;

    la_wb_state_e      r_state;
    la_wb_cmd_t        r_cmd;
    logic              r_cyc;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_dat;
    logic              w_expired;

    assign cmd_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_dat   = r_rsp_dat;
    // Classic single transfer: strobe and cycle are always identical.
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_cyc;
    assign wbm_we_o  = r_cmd.we;
    assign wbm_adr_o = ADDR_W'(r_cmd.adr);
    assign wbm_dat_o = DATA_W'(r_cmd.dat);
    assign wbm_sel_o = SEL_W'(r_cmd.sel);

`ifdef LA_WB_TIMEOUT_EN
    logic r_rsp_err;
    logic w_ctr_clear;
    logic w_ctr_en;

    assign w_ctr_clear = (r_state == IDLE) && cmd_valid;
    assign w_ctr_en    = (r_state == BUS) && !wbm_ack_i;
    assign rsp_err     = r_rsp_err;

    la_wb_timeout_ctr u_timeout_ctr (
        .i_clk     (wb_clk_i),
        .i_rst     (wb_rst_i),
        .i_clear   (w_ctr_clear),
        .i_enable  (w_ctr_en),
        .i_limit   (LA_WB_CNT_W'(TIMEOUT_CYCLES)),
        .o_expired (w_expired)
    );

    // Error flag: set on abort, cleared on normal acknowledge.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_rsp_err <= 1'b0;
        end else if (r_state == BUS) begin
            if (wbm_ack_i) begin
                r_rsp_err <= 1'b0;
            end else if (w_expired) begin
                r_rsp_err <= 1'b1;
            end
        end
    end
`else
    // No abort path: the bus waits for acknowledge indefinitely.
    assign w_expired = 1'b0;
    assign rsp_err   = 1'b0;
    // TIMEOUT_CYCLES only matters when the timeout is built in.
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout_limit
    end
`endif

    // Transaction sequencer: accept command, run one bus transfer, hold response.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= IDLE;
            r_cmd       <= '0;
            r_cyc       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_cmd.we  <= cmd_we;
                        r_cmd.adr <= LA_WB_ADDR_W'(cmd_adr);
                        r_cmd.dat <= LA_WB_DATA_W'(cmd_dat);
                        r_cmd.sel <= LA_WB_SEL_W'(cmd_sel);
                        r_cyc     <= 1'b1;
                        r_state   <= BUS;
                    end
                end
                BUS: begin
                    // Acknowledge takes priority over a simultaneous timeout.
                    if (wbm_ack_i) begin
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_dat   <= r_cmd.we ? '0 : wbm_dat_i;
                        r_state     <= RESP;
                    end else if (w_expired) begin
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_dat   <= '0;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
